io_responder: RTL
=================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter DBITS, default 16: data/address width.
REQ-002 SHALL have parameter PRESCALE, default 50000: CLK cycles per timer tick.
REQ-003 SHALL have parameter DEBOUNCE, default 250000: stable cycles required to accept a key change.
REQ-004 SHALL have port CLK  input  1: single clock; all state on posedge CLK.
REQ-005 SHALL have port RESETN  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port ADDR  input  DBITS: data bus byte address from processor.
REQ-007 SHALL have port DIN  input  DBITS: store data.
REQ-008 SHALL have port WE  input  1: store strobe, sampled at posedge CLK.
REQ-009 SHALL have port DOUT  output  DBITS: load data, combinational from ADDR and registers.
REQ-010 SHALL have port SEL  output  1: ADDR[15:4]==12'hFFF, i.e. an I/O page hit.
REQ-011 SHALL have port KEY  input  4: raw pushbuttons, asynchronous, active-low.
REQ-012 SHALL have port SW  input  10: raw switches, asynchronous.
REQ-013 SHALL have port HEXVAL  output  16: value for the four seven-segment digits.
REQ-014 SHALL have port LEDR  output  10, and port LEDG  output  8: LED registers.
REQ-015 SHALL have port IRQ  output  1: OR of the enabled sticky status bits.

Function
REQ-016 KEY and SW SHALL each pass through a 2-flop synchronizer before any use.
REQ-017 Each key SHALL be debounced: the accepted state changes only after the synchronized input differs from it for DEBOUNCE consecutive cycles, and the counter clears on any bounce.
REQ-018 Address map (reads): FFF0 = {12'b0, debounced KEY}; FFF2 = {6'b0, synced SW}; FFF4 = {12'b0, KEYEDGE}; FFF6 = TCNT; FFF8 = HEXVAL; FFFA = {6'b0, LEDR}; FFFC = {8'b0, LEDG}; FFFE = {14'b0, TIE, TDONE}; any other address = 16'hDEAD.
REQ-019 Writes when WE=1: FFF8 loads HEXVAL; FFFA loads LEDR from DIN[9:0]; FFFC loads LEDG from DIN[7:0]; FFF6 loads TCNT; FFF4 clears the KEYEDGE bits where DIN is 1 (write-1-to-clear); FFFE clears TDONE if DIN[0]=1 and loads TIE from DIN[1]; FFF0, FFF2 and unmapped addresses are ignored.
REQ-020 Register writes SHALL take effect at the posedge where WE is sampled, so a read in the next cycle returns the new value.
REQ-021 KEYEDGE[i] SHALL set in the cycle after debounced KEY[i] goes 1->0 (press).
REQ-022 If an edge set and a W1C clear hit the same KEYEDGE bit in the same cycle, the set SHALL win.
REQ-023 The prescaler SHALL count 0..PRESCALE-1 and wrap; it runs continuously.
REQ-024 On each prescaler wrap with TCNT!=0, TCNT SHALL decrement by 1; when TCNT reaches 0 by decrement, TDONE SHALL set in that same cycle.
REQ-025 TCNT SHALL hold at 0, with no wrap to FFFF.
REQ-026 A CPU write to TCNT coinciding with a tick SHALL win, with no decrement that cycle.
REQ-027 Writing TCNT=0 SHALL NOT set TDONE.
REQ-028 IRQ SHALL equal (TIE & TDONE) | (|KEYEDGE), registered.

Reset
REQ-029 While RESETN=0: HEXVAL=0, LEDR=0, LEDG=0, TCNT=0, TDONE=0, TIE=0, KEYEDGE=0, IRQ=0, and the prescaler and debounce counters are 0.
REQ-030 While RESETN=0, the synchronizers and debounced key state SHALL be 4'hF / all ones (released), and SW synchronizers 0.
REQ-031 Reset asserted mid-count SHALL abandon the timer and debounce without setting any status bit.

Structure
REQ-032 The address constants (FFF0..FFFE), the 16'hDEAD unmapped value and the status bit positions SHALL live in a shared package used by the processor and this block.
REQ-033 Per-key synchronizer plus debounce SHALL be one sub-module, key_debounce, instantiated 4 times.

Verification
REQ-034 Bench SHALL use PRESCALE=4 and DEBOUNCE=3.
REQ-035 Reset and unmapped read: release RESETN, read FFF8/FFFA/FFFC/FFFE -> 0; read 0x1234 -> DEAD with SEL=0; read FFF0 -> 000F.
REQ-036 LEDs: write FFFA=03FF, then FFFC=01A5 -> next cycle LEDR=3FF, LEDG=A5, and read FFFC -> 00A5.
REQ-037 Key edge: hold KEY[2]=0 for 10 cycles -> KEYEDGE=4 and IRQ=1; a 2-cycle glitch on KEY[1] -> no edge; write FFF4=0004 -> KEYEDGE=0, IRQ=0.
REQ-038 Timer: write FFFE=0002, FFF6=0003 -> TCNT reads 2, 1, 0 at successive ticks; TDONE=1, IRQ=1; TCNT stays 0; write FFFE=0001 -> TDONE=0.
REQ-039 Collisions: write FFF6=0005 on a tick cycle -> reads 5; W1C of KEYEDGE[0] in the press-set cycle -> bit stays 1.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared I/O page definitions: register addresses, unmapped read value,
// timer control bit positions and a small address decoder.
package io_responder_pkg;

    localparam logic [11:0] IO_PAGE         = 12'hFFF;

    localparam logic [15:0] IO_ADDR_KEY     = 16'hFFF0;
    localparam logic [15:0] IO_ADDR_SW      = 16'hFFF2;
    localparam logic [15:0] IO_ADDR_KEYEDGE = 16'hFFF4;
    localparam logic [15:0] IO_ADDR_TCNT    = 16'hFFF6;
    localparam logic [15:0] IO_ADDR_HEX     = 16'hFFF8;
    localparam logic [15:0] IO_ADDR_LEDR    = 16'hFFFA;
    localparam logic [15:0] IO_ADDR_LEDG    = 16'hFFFC;
    localparam logic [15:0] IO_ADDR_TCTL    = 16'hFFFE;

    localparam logic [15:0] IO_UNMAPPED     = 16'hDEAD;

    // Timer control/status word layout
    localparam int TCTL_TDONE_BIT = 0;
    localparam int TCTL_TIE_BIT   = 1;

    typedef enum logic [3:0] {
        REG_KEY,
        REG_SW,
        REG_KEYEDGE,
        REG_TCNT,
        REG_HEX,
        REG_LEDR,
        REG_LEDG,
        REG_TCTL,
        REG_NONE
    } io_reg_e;

    // Map a byte address onto one of the I/O registers; odd or foreign
    // addresses fall through to REG_NONE.
    function automatic io_reg_e io_decode(input logic [15:0] addr);
        io_reg_e r;
        r = REG_NONE;
        case (addr)
            IO_ADDR_KEY:     r = REG_KEY;
            IO_ADDR_SW:      r = REG_SW;
            IO_ADDR_KEYEDGE: r = REG_KEYEDGE;
            IO_ADDR_TCNT:    r = REG_TCNT;
            IO_ADDR_HEX:     r = REG_HEX;
            IO_ADDR_LEDR:    r = REG_LEDR;
            IO_ADDR_LEDG:    r = REG_LEDG;
            IO_ADDR_TCTL:    r = REG_TCTL;
            default:         r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// Processor data bus as seen by a memory-mapped peripheral.
interface io_responder_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] ADDR;
    logic [DBITS-1:0] DIN;
    logic             WE;
    logic [DBITS-1:0] DOUT;
    logic             SEL;

    modport master (output ADDR, output DIN, output WE, input DOUT, input SEL);
    modport slave  (input ADDR, input DIN, input WE, output DOUT, output SEL);
endinterface

// File: rtl/io_responder_key_debounce.sv
// One pushbutton: two-flop synchronizer followed by a debounce counter.
// The accepted level only moves after the synchronized input has
// disagreed with it for DEBOUNCE consecutive cycles.
module key_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_db
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count disagreeing cycles; any agreement (bounce back) restarts the count
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer and debounce state; keys rest released (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_db = db_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O page: keys, switches, LEDs, hex display value and a
// countdown timer with interrupt. Reads are combinational, writes land on
// the clock edge that samples WE.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int DBITS    = 16,
    parameter int PRESCALE = 50000,
    parameter int DEBOUNCE = 250000
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    io_responder_if.slave        bus,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SW,
    output logic [15:0]          HEXVAL,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG,
    output logic                 IRQ
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [3:0]    key_db;
    logic [3:0]    db_prev_q;
    logic [3:0]    key_fall;
    logic [9:0]    sw_s1_q, sw_s2_q;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    logic [15:0]   hex_q, hex_d;
    logic [9:0]    ledr_q, ledr_d;
    logic [7:0]    ledg_q, ledg_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic          tdone_q, tdone_d;
    logic          tie_q, tie_d;
    logic [3:0]    keyedge_q, keyedge_d;
    logic          irq_q, irq_d;

    io_reg_e       reg_sel;
    logic [15:0]   addr16;
    logic [15:0]   din16;
    logic [15:0]   rd_val;

    assign addr16  = bus.ADDR[15:0];
    assign din16   = bus.DIN[15:0];
    assign reg_sel = io_decode(addr16);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_key_debounce (
                .clk     (CLK),
                .rst_n   (RESETN),
                .key_raw (KEY[gi]),
                .key_db  (key_db[gi])
            );
        end
    endgenerate

    // A press is a 1->0 transition of the debounced level
    assign key_fall = db_prev_q & ~key_db;
    assign tick     = (presc_q == PW'(PRESCALE - 1));

    // Next-state for prescaler, CPU-writable registers, timer and status
    always_comb begin
        presc_d   = tick ? '0 : presc_q + PW'(1);
        hex_d     = hex_q;
        ledr_d    = ledr_q;
        ledg_d    = ledg_q;
        tcnt_d    = tcnt_q;
        tdone_d   = tdone_q;
        tie_d     = tie_q;
        keyedge_d = keyedge_q;

        if (bus.WE) begin
            case (reg_sel)
                REG_HEX:     hex_d     = din16;
                REG_LEDR:    ledr_d    = din16[9:0];
                REG_LEDG:    ledg_d    = din16[7:0];
                REG_KEYEDGE: keyedge_d = keyedge_q & ~din16[3:0];
                REG_TCTL: begin
                    tie_d = din16[TCTL_TIE_BIT];
                    if (din16[TCTL_TDONE_BIT]) begin
                        tdone_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // New presses are applied after the clear so a same-cycle set wins
        keyedge_d = keyedge_d | key_fall;

        // CPU load beats the tick; decrement saturates at zero and only a
        // decrement into zero raises TDONE (after any clear, so set wins)
        if (bus.WE && reg_sel == REG_TCNT) begin
            tcnt_d = din16;
        end else if (tick && tcnt_q != 16'd0) begin
            tcnt_d = tcnt_q - 16'd1;
            if (tcnt_q == 16'd1) begin
                tdone_d = 1'b1;
            end
        end

        irq_d = (tie_d & tdone_d) | (|keyedge_d);
    end

    // State registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            db_prev_q <= 4'hF;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            presc_q   <= '0;
            hex_q     <= '0;
            ledr_q    <= '0;
            ledg_q    <= '0;
            tcnt_q    <= '0;
            tdone_q   <= 1'b0;
            tie_q     <= 1'b0;
            keyedge_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            db_prev_q <= key_db;
            sw_s1_q   <= SW;
            sw_s2_q   <= sw_s1_q;
            presc_q   <= presc_d;
            hex_q     <= hex_d;
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            tcnt_q    <= tcnt_d;
            tdone_q   <= tdone_d;
            tie_q     <= tie_d;
            keyedge_q <= keyedge_d;
            irq_q     <= irq_d;
        end
    end

    // Combinational load data for the addressed register
    always_comb begin
        rd_val = IO_UNMAPPED;
        case (reg_sel)
            REG_KEY:     rd_val = {12'b0, key_db};
            REG_SW:      rd_val = {6'b0, sw_s2_q};
            REG_KEYEDGE: rd_val = {12'b0, keyedge_q};
            REG_TCNT:    rd_val = tcnt_q;
            REG_HEX:     rd_val = hex_q;
            REG_LEDR:    rd_val = {6'b0, ledr_q};
            REG_LEDG:    rd_val = {8'b0, ledg_q};
            REG_TCTL: begin
                rd_val                 = '0;
                rd_val[TCTL_TIE_BIT]   = tie_q;
                rd_val[TCTL_TDONE_BIT] = tdone_q;
            end
            default:     rd_val = IO_UNMAPPED;
        endcase
    end

    assign bus.DOUT = DBITS'(rd_val);
    assign bus.SEL  = (addr16[15:4] == IO_PAGE);
    assign HEXVAL   = hex_q;
    assign LEDR     = ledr_q;
    assign LEDG     = ledg_q;
    assign IRQ      = irq_q;

endmodule
